// File: rtl/crc32_stream_checker_if.sv
// Stream and result handshake bundle for crc32_stream_checker.
interface crc32_stream_checker_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [31:0]          s_data;
    logic                 s_last;
    logic                 res_valid;
    logic                 res_ready;
    logic                 res_pass;
    logic [31:0]          res_crc;
    logic [CNT_WIDTH-1:0] res_count;
    logic [15:0]          err_cnt;

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_pass, res_crc, res_count, err_cnt
    );

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_pass, res_crc, res_count, err_cnt
    );
endinterface

// File: rtl/crc32_stream_checker.sv
// Receive-side CRC-32 checker: accumulates data words, compares against the trailing CRC word.
// Optional failed-frame counter enabled by defining CRC_CHECKER_ERR_CNT_EN.
module crc32_stream_checker #(
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          clr,
    crc32_stream_checker_if.slave         strm
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        RESULT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pass_q, pass_d;
    logic [31:0]          crc_q, crc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]          final_crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 32; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign final_crc = acc_q ^ CRC_XOROUT;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= RUN;
            acc_q   <= CRC_INIT;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            crc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            crc_q   <= crc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        crc_d   = crc_q;
        count_d = count_q;
        if (clr) begin
            // abort wins over any beat or result handshake in the same cycle
            acc_d   = CRC_INIT;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (strm.s_valid) begin
                        if (strm.s_last) begin
                            crc_d   = final_crc;
                            pass_d  = (final_crc == strm.s_data);
                            count_d = cnt_q;
                            state_d = RESULT;
                        end else begin
                            acc_d = crc_step(acc_q, strm.s_data);
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                RESULT: begin
                    if (strm.res_ready) begin
                        acc_d   = CRC_INIT;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign strm.s_ready   = (state_q == RUN);
    assign strm.res_valid = (state_q == RESULT);
    assign strm.res_pass  = pass_q;
    assign strm.res_crc   = crc_q;
    assign strm.res_count = count_q;

`ifdef CRC_CHECKER_ERR_CNT_EN
    logic [15:0] err_q;
    logic        last_fail;

    assign last_fail = (state_q == RUN) && strm.s_valid && strm.s_last && !clr
                       && (final_crc != strm.s_data);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            err_q <= '0;
        end else if (last_fail && (err_q != '1)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign strm.err_cnt = err_q;
`else
    assign strm.err_cnt = '0;
`endif

endmodule
